timer_set_ctrl: RTL and testbench

TIMER_SET_CTRL -- requirements
Module: timer_set_ctrl

---
 rtl/clock_pkg.sv | 20 ++
 rtl/blink_gen.sv | 28 ++
 rtl/timer_set_ctrl.sv | 108 ++++++++++
 tb/tb_timer_set_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared clock definitions: mode encoding, field limits and a wrap-increment helper.
package clock_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } mode_e;

  localparam logic [5:0] HOUR_MAX = 6'd23;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [5:0] SEC_MAX  = 6'd59;

  // >= rather than == keeps the result legal even from an out-of-range input.
  function automatic logic [5:0] inc_wrap(input logic [5:0] val, input logic [5:0] max);
    return (val >= max) ? 6'd0 : val + 6'd1;
  endfunction

endpackage

// File: rtl/blink_gen.sv
// Blink phase generator: phase toggles every DIV cycles while active; clr or !active restarts it shown.
module blink_gen #(
  parameter int DIV = 25000000
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic clr,
  output logic phase
);

  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr || !active) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == CNT_W'(DIV - 1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/timer_set_ctrl.sv
// Time-of-day counter with RUN/SET_H/SET_M/SET_S modes driven by mode/inc buttons.
// Optional field blinking in SET modes is enabled by defining TIMER_SET_BLINK_EN.
module timer_set_ctrl
  import clock_pkg::*;
#(
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [5:0] hours,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic [2:0] blank
);

  if (BLINK_DIV < 2) begin : g_bad_div
    $error("BLINK_DIV must be at least 2");
  end

  mode_e      state_q, state_d;
  logic [5:0] hours_d, minutes_d, seconds_d;
  logic       inc_accept;

  // btn_mode wins over a simultaneous btn_inc; RUN never accepts increments.
  assign inc_accept = btn_inc && !btn_mode && (state_q != RUN);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d   = state_q;
    hours_d   = hours;
    minutes_d = minutes;
    seconds_d = seconds;

    if (state_q == RUN && tick_1hz) begin
      seconds_d = inc_wrap(seconds, SEC_MAX);
      if (seconds >= SEC_MAX) begin
        minutes_d = inc_wrap(minutes, MIN_MAX);
        if (minutes >= MIN_MAX) hours_d = inc_wrap(hours, HOUR_MAX);
      end
    end

    if (inc_accept) begin
      case (state_q)
        SET_H:   hours_d   = inc_wrap(hours, HOUR_MAX);
        SET_M:   minutes_d = inc_wrap(minutes, MIN_MAX);
        SET_S:   seconds_d = inc_wrap(seconds, SEC_MAX);
        default: ;
      endcase
    end

    if (btn_mode) begin
      case (state_q)
        RUN:     state_d = SET_H;
        SET_H:   state_d = SET_M;
        SET_M:   state_d = SET_S;
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state_q <= RUN;
      hours   <= '0;
      minutes <= '0;
      seconds <= '0;
    end else begin
      state_q <= state_d;
      hours   <= hours_d;
      minutes <= minutes_d;
      seconds <= seconds_d;
    end
  end

  assign mode = state_q;

`ifdef TIMER_SET_BLINK_EN
  logic blink_phase;

  blink_gen #(
    .DIV(BLINK_DIV)
  ) u_blink_gen (
    .clk   (clk),
    .rst   (rst),
    .active(state_q != RUN),
    .clr   (btn_mode || inc_accept),
    .phase (blink_phase)
  );

  always_comb begin
    blank = 3'b000;
    case (state_q)
      SET_H:   blank = {blink_phase, 2'b00};
      SET_M:   blank = {1'b0, blink_phase, 1'b0};
      SET_S:   blank = {2'b00, blink_phase};
      default: blank = 3'b000;
    endcase
  end
`else
  assign blank = 3'b000;
`endif

endmodule

// File: tb/tb_timer_set_ctrl.sv
// Directed self-checking bench for timer_set_ctrl (BLINK_DIV=4); blink checks follow TIMER_SET_BLINK_EN.
module tb_timer_set_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [5:0] hours, minutes, seconds;
  logic [1:0] mode;
  logic [2:0] blank;

  int checks = 0;
  int errors = 0;

  timer_set_ctrl #(.BLINK_DIV(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .tick_1hz(tick_1hz),
    .btn_mode(btn_mode),
    .btn_inc (btn_inc),
    .hours   (hours),
    .minutes (minutes),
    .seconds (seconds),
    .mode    (mode),
    .blank   (blank)
  );

  always #5 clk = ~clk;

  // One clock with the given inputs high; outputs are settled on return (#1 after the edge).
  task automatic step(input logic r, input logic m, input logic i, input logic t);
    @(negedge clk);
    rst = r; btn_mode = m; btn_inc = i; tick_1hz = t;
    @(posedge clk);
    #1;
    rst = 1'b0; btn_mode = 1'b0; btn_inc = 1'b0; tick_1hz = 1'b0;
  endtask

  task automatic load_time(input int h, input int m, input int s);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int k = 0; k < h; k++) step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    for (int k = 0; k < m; k++) step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    for (int k = 0; k < s; k++) step(0, 0, 1, 0);
    step(0, 1, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 1, 1, 1);
    checks++;
    if ({hours, minutes, seconds, mode, blank} !== {6'd0, 6'd0, 6'd0, 2'd0, 3'd0}) begin
      errors++;
      $display("FAIL reset: got %0d:%0d:%0d mode=%0d blank=%b, want 0:0:0 mode=0 blank=000",
               hours, minutes, seconds, mode, blank);
    end
  endtask

  task automatic test_rollover();
    load_time(23, 59, 58);
    checks++;
    if ({mode, hours, minutes, seconds} !== {2'd0, 6'd23, 6'd59, 6'd58}) begin
      errors++;
      $display("FAIL load_235958: got mode=%0d %0d:%0d:%0d, want mode=0 23:59:58", mode, hours, minutes, seconds);
    end
    step(0, 0, 0, 1);
    checks++;
    if ({hours, minutes, seconds} !== {6'd23, 6'd59, 6'd59}) begin
      errors++;
      $display("FAIL tick_235959: got %0d:%0d:%0d, want 23:59:59", hours, minutes, seconds);
    end
    step(0, 0, 0, 1);
    checks++;
    if ({hours, minutes, seconds, blank} !== {6'd0, 6'd0, 6'd0, 3'd0}) begin
      errors++;
      $display("FAIL tick_wrap: got %0d:%0d:%0d blank=%b, want 0:0:0 blank=000", hours, minutes, seconds, blank);
    end
  endtask

  task automatic test_inc_ignored_run();
    load_time(1, 2, 3);
    step(0, 0, 1, 0);
    checks++;
    if ({mode, hours, minutes, seconds} !== {2'd0, 6'd1, 6'd2, 6'd3}) begin
      errors++;
      $display("FAIL inc_in_run: got mode=%0d %0d:%0d:%0d, want mode=0 1:2:3", mode, hours, minutes, seconds);
    end
  endtask

  task automatic test_tick_mode_same();
    load_time(1, 2, 3);
    step(0, 1, 0, 1);
    checks++;
    if ({mode, hours, minutes, seconds} !== {2'd1, 6'd1, 6'd2, 6'd4}) begin
      errors++;
      $display("FAIL tick_and_mode: got mode=%0d %0d:%0d:%0d, want mode=1 1:2:4", mode, hours, minutes, seconds);
    end
  endtask

  task automatic test_set_hours();
    logic [5:0] exp_h;
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    checks++;
    if (mode !== 2'd1) begin
      errors++;
      $display("FAIL enter_set_h: got mode=%0d, want 1", mode);
    end
    exp_h = 6'd0;
    for (int k = 1; k <= 25; k++) begin
      step(0, 0, 1, 0);
      exp_h = (exp_h == 6'd23) ? 6'd0 : exp_h + 6'd1;
      checks++;
      if ({mode, hours, minutes, seconds} !== {2'd1, exp_h, 6'd0, 6'd0}) begin
        errors++;
        $display("FAIL set_h_inc%0d: got mode=%0d %0d:%0d:%0d, want mode=1 %0d:0:0",
                 k, mode, hours, minutes, seconds, exp_h);
      end
    end
  endtask

  task automatic test_set_min_wrap();
    load_time(10, 59, 20);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 1, 0);
    checks++;
    if ({mode, hours, minutes, seconds} !== {2'd2, 6'd10, 6'd0, 6'd20}) begin
      errors++;
      $display("FAIL set_m_wrap: got mode=%0d %0d:%0d:%0d, want mode=2 10:0:20", mode, hours, minutes, seconds);
    end
    for (int k = 0; k < 3; k++) step(0, 0, 0, 1);
    checks++;
    if ({mode, hours, minutes, seconds} !== {2'd2, 6'd10, 6'd0, 6'd20}) begin
      errors++;
      $display("FAIL tick_in_set: got mode=%0d %0d:%0d:%0d, want mode=2 10:0:20", mode, hours, minutes, seconds);
    end
    // Leaving SET must not release a queued tick.
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    checks++;
    if ({mode, seconds} !== {2'd0, 6'd20}) begin
      errors++;
      $display("FAIL no_queued_tick: got mode=%0d sec=%0d, want mode=0 sec=20", mode, seconds);
    end
  endtask

  task automatic test_mode_inc_same();
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    for (int k = 0; k < 5; k++) step(0, 0, 1, 0);
    step(0, 1, 1, 0);
    checks++;
    if ({mode, hours, minutes, seconds} !== {2'd2, 6'd5, 6'd0, 6'd0}) begin
      errors++;
      $display("FAIL mode_and_inc: got mode=%0d %0d:%0d:%0d, want mode=2 5:0:0", mode, hours, minutes, seconds);
    end
  endtask

  task automatic test_rst_mid_set();
    load_time(12, 34, 56);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    checks++;
    if ({mode, hours, minutes, seconds} !== {2'd2, 6'd12, 6'd34, 6'd56}) begin
      errors++;
      $display("FAIL pre_rst_set_m: got mode=%0d %0d:%0d:%0d, want mode=2 12:34:56", mode, hours, minutes, seconds);
    end
    step(1, 0, 1, 0);
    checks++;
    if ({mode, hours, minutes, seconds, blank} !== {2'd0, 6'd0, 6'd0, 6'd0, 3'd0}) begin
      errors++;
      $display("FAIL rst_mid_set: got mode=%0d %0d:%0d:%0d blank=%b, want mode=0 0:0:0 blank=000",
               mode, hours, minutes, seconds, blank);
    end
  endtask

  task automatic test_blink();
    logic [2:0] exp_b;
    step(1, 0, 0, 0);
`ifdef TIMER_SET_BLINK_EN
    step(0, 1, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 0, 0);
      exp_b = (k == 4) ? 3'b100 : 3'b000;
      checks++;
      if (blank !== exp_b) begin
        errors++;
        $display("FAIL blink_set_h%0d: got blank=%b, want %b", k, blank, exp_b);
      end
    end
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    checks++;
    if ({mode, blank} !== {2'd3, 3'b000}) begin
      errors++;
      $display("FAIL blink_enter_s: got mode=%0d blank=%b, want mode=3 blank=000", mode, blank);
    end
    for (int k = 1; k <= 10; k++) begin
      step(0, 0, 0, 0);
      exp_b = ((k / 4) % 2 == 1) ? 3'b001 : 3'b000;
      checks++;
      if (blank !== exp_b) begin
        errors++;
        $display("FAIL blink_s_cyc%0d: got blank=%b, want %b", k, blank, exp_b);
      end
    end
    step(0, 0, 1, 0);
    checks++;
    if ({seconds, blank} !== {6'd1, 3'b000}) begin
      errors++;
      $display("FAIL blink_inc_clear: got sec=%0d blank=%b, want sec=1 blank=000", seconds, blank);
    end
    for (int k = 1; k <= 4; k++) begin
      step(0, 0, 0, 0);
      exp_b = (k == 4) ? 3'b001 : 3'b000;
      checks++;
      if (blank !== exp_b) begin
        errors++;
        $display("FAIL blink_restart%0d: got blank=%b, want %b", k, blank, exp_b);
      end
    end
    step(0, 1, 0, 0);
    checks++;
    if ({mode, blank} !== {2'd0, 3'b000}) begin
      errors++;
      $display("FAIL blink_run: got mode=%0d blank=%b, want mode=0 blank=000", mode, blank);
    end
`else
    for (int k = 1; k <= 3; k++) begin
      step(0, 1, 0, 0);
      for (int j = 0; j < 6; j++) step(0, 0, 0, 0);
      checks++;
      if (blank !== 3'b000) begin
        errors++;
        $display("FAIL blank_tied_mode%0d: got blank=%b, want 000", k, blank);
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_rollover();
    test_inc_ignored_run();
    test_tick_mode_same();
    test_set_hours();
    test_set_min_wrap();
    test_mode_inc_same();
    test_rst_mid_set();
    test_blink();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
